// File: rtl/mdio_phy_model_if.sv
// mdio_phy_model_if
//   Pin-level bundle between the NIC management master and the PHY model.
//   Signals:
//     MDC        management clock from the master
//     MDIO_I     resolved MDIO pin value seen by the PHY
//     MDIO_O     MDIO value driven by the PHY
//     MDIO_T     PHY tristate enable, 1 = released, 0 = drive MDIO_O
//     PHY_RST_N  PHY hardware reset from the master, active low
//     FRAME_DONE one-cycle pulse, frame completed at a matching address
//     FRAME_ERR  one-cycle pulse, malformed frame
//   Modports: master (NIC side), slave (PHY model side).
interface mdio_phy_model_if;
  logic MDC;
  logic MDIO_I;
  logic MDIO_O;
  logic MDIO_T;
  logic PHY_RST_N;
  logic FRAME_DONE;
  logic FRAME_ERR;

  modport master (
    output MDC, MDIO_I, PHY_RST_N,
    input  MDIO_O, MDIO_T, FRAME_DONE, FRAME_ERR
  );

  modport slave (
    input  MDC, MDIO_I, PHY_RST_N,
    output MDIO_O, MDIO_T, FRAME_DONE, FRAME_ERR
  );
endinterface

// File: rtl/mdio_phy_model.sv
// mdio_phy_model
//   Clause-22 MDIO management slave modelling an external PHY. MDC, MDIO and
//   PHY_RST_N are oversampled on CLK through 2-flop synchronizers; frames are
//   decoded one bit per detected MDC rising edge, read data is driven on
//   detected MDC falling edges. Holds a 32x16 register file (regs 1..3 are
//   read-only constants, reg0 bit15 is a self-clearing soft reset).
//   Ports:
//     CLK    system clock (100 MHz)
//     RESET  asynchronous active-high reset
//     mif    slave modport of mdio_phy_model_if (MDC, MDIO_I, MDIO_O, MDIO_T,
//            PHY_RST_N, FRAME_DONE, FRAME_ERR)
//   Build option:
//     MDIO_PREAMBLE_SUPPRESS_EN  when defined, a single preamble 1 is enough to
//            accept a frame and reg1 bit6 reads 1.
module mdio_phy_model #(
  parameter logic [4:0]  PHY_ADDR   = 5'd0,
  parameter logic [15:0] PHY_ID1    = 16'h0141,
  parameter logic [15:0] PHY_ID2    = 16'h0CC2,
  parameter logic [15:0] STATUS_VAL = 16'h796D
) (
  input  logic CLK,
  input  logic RESET,
  mdio_phy_model_if.slave mif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ST    = 3'd1,
    OP    = 3'd2,
    PHYAD = 3'd3,
    REGAD = 3'd4,
    TA    = 3'd5,
    RDATA = 3'd6,
    WDATA = 3'd7
  } state_t;

  localparam logic [15:0] REG0_DEF = 16'h1140;
  localparam logic [5:0]  PRE_MAX  = 6'd32;
  localparam int          NREGS    = 32;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0]  PRE_MIN   = 6'd1;
  localparam logic [15:0] STATUS_RD = STATUS_VAL | 16'h0040;
`else
  localparam logic [5:0]  PRE_MIN   = 6'd32;
  localparam logic [15:0] STATUS_RD = STATUS_VAL;
`endif

  logic [1:0]  mdc_sync_r;
  logic [1:0]  mdio_sync_r;
  logic [1:0]  rstn_sync_r;
  logic        mdc_prev_r;
  logic        mdc_s;
  logic        mdio_s;
  logic        rise_s;
  logic        fall_s;
  logic        phy_rst_s;

  state_t      state_r, state_next;
  logic [5:0]  cnt_r, cnt_next;
  logic [4:0]  bit_cnt_r, bit_cnt_next;
  logic [15:0] shift_r, shift_next;
  logic        op_r, op_next;
  logic        is_read_r, is_read_next;
  logic [4:0]  phyad_r, phyad_next;
  logic [4:0]  regad_r, regad_next;
  logic        match_r, match_next;
  logic        mdio_o_r, mdio_o_next;
  logic        mdio_t_r, mdio_t_next;
  logic        done_r, done_next;
  logic        err_r, err_next;
  logic        wr_en_s;
  logic [15:0] wr_data_s;
  logic [15:0] rd_data_s;
  logic [4:0]  phyad_shift_s;
  logic [4:0]  regad_shift_s;
  logic        soft_clr_s;

  logic [15:0] regs_r [NREGS];

  // Synchronize the asynchronous pins and remember the previous MDC level.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mdc_sync_r  <= 2'b00;
      mdio_sync_r <= 2'b11;
      rstn_sync_r <= 2'b00;
      mdc_prev_r  <= 1'b0;
    end else begin
      mdc_sync_r  <= {mdc_sync_r[0], mif.MDC};
      mdio_sync_r <= {mdio_sync_r[0], mif.MDIO_I};
      rstn_sync_r <= {rstn_sync_r[0], mif.PHY_RST_N};
      mdc_prev_r  <= mdc_sync_r[1];
    end
  end

  assign mdc_s         = mdc_sync_r[1];
  assign mdio_s        = mdio_sync_r[1];
  assign rise_s        = mdc_s & ~mdc_prev_r;
  assign fall_s        = ~mdc_s & mdc_prev_r;
  assign phy_rst_s     = ~rstn_sync_r[1];
  assign phyad_shift_s = {phyad_r[3:0], mdio_s};
  assign regad_shift_s = {regad_r[3:0], mdio_s};
  assign wr_data_s     = {shift_r[14:0], mdio_s};
  // Writing reg0 with bit15 set restores every register to its default.
  assign soft_clr_s    = wr_en_s & (regad_r == 5'd0) & wr_data_s[15];

  // Register read mux: regs 1..3 are constants, the rest come from storage.
  always_comb begin
    rd_data_s = regs_r[regad_r];
    case (regad_r)
      5'd1:    rd_data_s = STATUS_RD;
      5'd2:    rd_data_s = PHY_ID1;
      5'd3:    rd_data_s = PHY_ID2;
      default: rd_data_s = regs_r[regad_r];
    endcase
  end

  // Frame decoder: next-state and next-output logic.
  always_comb begin
    state_next   = state_r;
    cnt_next     = cnt_r;
    bit_cnt_next = bit_cnt_r;
    shift_next   = shift_r;
    op_next      = op_r;
    is_read_next = is_read_r;
    phyad_next   = phyad_r;
    regad_next   = regad_r;
    match_next   = match_r;
    mdio_o_next  = mdio_o_r;
    mdio_t_next  = mdio_t_r;
    done_next    = 1'b0;
    err_next     = 1'b0;
    wr_en_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          if (mdio_s) begin
            if (cnt_r != PRE_MAX) begin
              cnt_next = cnt_r + 6'd1;
            end else begin
              cnt_next = cnt_r;
            end
          end else if (cnt_r >= PRE_MIN) begin
            // This 0 is the first start bit.
            state_next = ST;
            cnt_next   = 6'd0;
          end else begin
            cnt_next = 6'd0;
          end
        end else begin
          cnt_next = cnt_r;
        end
      end
      ST: begin
        if (rise_s) begin
          if (mdio_s) begin
            state_next   = OP;
            bit_cnt_next = 5'd0;
          end else begin
            err_next   = 1'b1;
            state_next = IDLE;
            cnt_next   = 6'd0;
          end
        end else begin
          state_next = ST;
        end
      end
      OP: begin
        if (rise_s) begin
          if (bit_cnt_r == 5'd0) begin
            op_next      = mdio_s;
            bit_cnt_next = 5'd1;
          end else begin
            case ({op_r, mdio_s})
              2'b10: begin
                is_read_next = 1'b1;
                state_next   = PHYAD;
                bit_cnt_next = 5'd0;
              end
              2'b01: begin
                is_read_next = 1'b0;
                state_next   = PHYAD;
                bit_cnt_next = 5'd0;
              end
              default: begin
                err_next   = 1'b1;
                state_next = IDLE;
                cnt_next   = 6'd0;
              end
            endcase
          end
        end else begin
          state_next = OP;
        end
      end
      PHYAD: begin
        if (rise_s) begin
          phyad_next = phyad_shift_s;
          if (bit_cnt_r == 5'd4) begin
            match_next   = (phyad_shift_s == PHY_ADDR);
            state_next   = REGAD;
            bit_cnt_next = 5'd0;
          end else begin
            bit_cnt_next = bit_cnt_r + 5'd1;
          end
        end else begin
          state_next = PHYAD;
        end
      end
      REGAD: begin
        if (rise_s) begin
          regad_next = regad_shift_s;
          if (bit_cnt_r == 5'd4) begin
            state_next   = TA;
            bit_cnt_next = 5'd0;
          end else begin
            bit_cnt_next = bit_cnt_r + 5'd1;
          end
        end else begin
          state_next = REGAD;
        end
      end
      TA: begin
        if (is_read_r) begin
          // Read turnaround is counted on falling edges: stay released on the
          // first, drive the 0 on the second.
          if (fall_s) begin
            if (bit_cnt_r == 5'd0) begin
              bit_cnt_next = 5'd1;
            end else begin
              state_next   = RDATA;
              bit_cnt_next = 5'd0;
              shift_next   = rd_data_s;
              if (match_r) begin
                mdio_o_next = 1'b0;
                mdio_t_next = 1'b0;
              end else begin
                mdio_t_next = 1'b1;
              end
            end
          end else begin
            state_next = TA;
          end
        end else if (rise_s) begin
          if ((bit_cnt_r == 5'd0) && mdio_s) begin
            bit_cnt_next = 5'd1;
          end else if ((bit_cnt_r == 5'd1) && !mdio_s) begin
            state_next   = WDATA;
            bit_cnt_next = 5'd0;
          end else begin
            err_next   = 1'b1;
            state_next = IDLE;
            cnt_next   = 6'd0;
          end
        end else begin
          state_next = TA;
        end
      end
      RDATA: begin
        if (fall_s) begin
          if (!bit_cnt_r[4]) begin
            if (match_r) begin
              mdio_o_next = shift_r[15];
              mdio_t_next = 1'b0;
            end else begin
              mdio_t_next = 1'b1;
            end
            shift_next   = {shift_r[14:0], 1'b0};
            bit_cnt_next = bit_cnt_r + 5'd1;
          end else begin
            // Falling edge after the last data bit: let go of the line.
            mdio_o_next = 1'b0;
            mdio_t_next = 1'b1;
            done_next   = match_r;
            state_next  = IDLE;
            cnt_next    = 6'd0;
          end
        end else begin
          state_next = RDATA;
        end
      end
      WDATA: begin
        if (rise_s) begin
          shift_next = wr_data_s;
          if (bit_cnt_r == 5'd15) begin
            wr_en_s    = match_r;
            done_next  = match_r;
            state_next = IDLE;
            cnt_next   = 6'd0;
          end else begin
            bit_cnt_next = bit_cnt_r + 5'd1;
          end
        end else begin
          state_next = WDATA;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = 6'd0;
      end
    endcase
  end

  // Decoder state and registered pin outputs; PHY_RST_N acts as a soft reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= IDLE;
      cnt_r     <= 6'd0;
      bit_cnt_r <= 5'd0;
      shift_r   <= 16'h0000;
      op_r      <= 1'b0;
      is_read_r <= 1'b0;
      phyad_r   <= 5'd0;
      regad_r   <= 5'd0;
      match_r   <= 1'b0;
      mdio_o_r  <= 1'b0;
      mdio_t_r  <= 1'b1;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else if (phy_rst_s) begin
      state_r   <= IDLE;
      cnt_r     <= 6'd0;
      bit_cnt_r <= 5'd0;
      shift_r   <= 16'h0000;
      op_r      <= 1'b0;
      is_read_r <= 1'b0;
      phyad_r   <= 5'd0;
      regad_r   <= 5'd0;
      match_r   <= 1'b0;
      mdio_o_r  <= 1'b0;
      mdio_t_r  <= 1'b1;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_next;
      cnt_r     <= cnt_next;
      bit_cnt_r <= bit_cnt_next;
      shift_r   <= shift_next;
      op_r      <= op_next;
      is_read_r <= is_read_next;
      phyad_r   <= phyad_next;
      regad_r   <= regad_next;
      match_r   <= match_next;
      mdio_o_r  <= mdio_o_next;
      mdio_t_r  <= mdio_t_next;
      done_r    <= done_next;
      err_r     <= err_next;
    end
  end

  // Register file storage with default restore and write commit.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 32'sd1; i < NREGS; i = i + 32'sd1) begin
        regs_r[i] <= 16'h0000;
      end
      regs_r[0] <= REG0_DEF;
    end else if (phy_rst_s || soft_clr_s) begin
      for (int i = 32'sd1; i < NREGS; i = i + 32'sd1) begin
        regs_r[i] <= 16'h0000;
      end
      regs_r[0] <= REG0_DEF;
    end else if (wr_en_s && (regad_r == 5'd0)) begin
      regs_r[0] <= {1'b0, wr_data_s[14:0]};
    end else if (wr_en_s && (regad_r > 5'd3)) begin
      regs_r[regad_r] <= wr_data_s;
    end else begin
      regs_r[0] <= regs_r[0];
    end
  end

  assign mif.MDIO_O     = mdio_o_r;
  assign mif.MDIO_T     = mdio_t_r;
  assign mif.FRAME_DONE = done_r;
  assign mif.FRAME_ERR  = err_r;

endmodule
